log2_compress: RTL and testbench

Pipelined, multi-channel log-compression stage for the ultrasound envelope path. It accepts one unsigned envelope sample per cycle and computes a fixed-point log2 using leading-one detection and a LUT-corrected fraction. It then applies a per-channel gain and offset and saturates to the display code width. It sits between envelope detection and scan conversion, and sustains one sample per cycle under a valid/ready stream with backpressure.

---
 rtl/log_pkg.sv | 43 ++++
 rtl/log2_lod.sv | 38 +++
 rtl/log2_compress.sv | 219 +++++++++++++++++++++
 tb/tb_log2_compress.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// ---------------------------------------------------------------------------
// log_pkg
// Shared constants and helpers for the log-compression stage.
//   GAIN_ONE        : unity gain in the unsigned Q8.8 config format
//   CFG_GAIN_WIDTH  : width of the per-channel gain register
//   lut_entry()     : elaboration-time generator for the fraction
//                     correction table, pure integer arithmetic so any
//                     tool can fold it to a constant
// ---------------------------------------------------------------------------
package log_pkg;

  localparam int CFG_GAIN_WIDTH = 16;
  localparam logic [CFG_GAIN_WIDTH-1:0] GAIN_ONE = 16'h0100;

  // Returns round((log2(1 + idx/2^lutBits) - idx/2^lutBits) * 2^fracBits).
  // log2 of the mantissa y (Q1.31) is extracted one bit at a time by
  // repeated squaring: whenever y^2 reaches 2 the next fraction bit is 1
  // and y is renormalised. 32 fraction bits leave ample margin for the
  // final rounding to fracBits.
  function automatic int lut_entry(input int idx, input int lutBits,
                                   input int fracBits);
    longint unsigned y;
    longint unsigned sq;
    longint unsigned acc;
    longint unsigned lin;
    longint unsigned diff;
    y   = (64'd1 << 31) + (64'(idx) << (31 - lutBits));
    acc = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      sq = (y * y) >> 31;
      if (sq >= (64'd2 << 31)) begin
        acc = acc | (64'd1 << b);
        y   = sq >> 1;
      end else begin
        y = sq;
      end
    end
    lin  = 64'(idx) << (32 - lutBits);
    diff = acc - lin;
    return int'((diff + (64'd1 << (31 - fracBits))) >> (32 - fracBits));
  endfunction

endpackage

// File: rtl/log2_lod.sv
// ---------------------------------------------------------------------------
// log2_lod
// Combinational leading-one detector and normaliser for the first stage.
//   data_i : unsigned sample
//   exp_o  : index of the most significant set bit (0 when data_i == 0)
//   frac_o : the FRAC_WIDTH bits just below the leading one, left-aligned
//            and zero-filled when fewer bits exist below it
// ---------------------------------------------------------------------------
module log2_lod #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic [SHIFT_WIDTH-1:0] exp_o,
  output logic [FRAC_WIDTH-1:0]  frac_o
);

  localparam int NORM_WIDTH = DATA_WIDTH + FRAC_WIDTH;
  localparam logic [SHIFT_WIDTH-1:0] TOP_INDEX = SHIFT_WIDTH'(DATA_WIDTH - 1);

  logic [SHIFT_WIDTH-1:0] shiftAmt;
  logic [NORM_WIDTH-1:0]  norm;

  // The sample is padded with FRAC_WIDTH zeros and shifted so the leading
  // one lands in the top data bit; the bits beneath it then form the
  // mantissa. A zero sample stays zero, giving exp 0 and mantissa 0.
  always_comb begin
    exp_o = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data_i[i]) exp_o = SHIFT_WIDTH'(i);
    end
    shiftAmt = TOP_INDEX - exp_o;
    norm     = {data_i, {FRAC_WIDTH{1'b0}}} << shiftAmt;
    frac_o   = FRAC_WIDTH'(norm >> (DATA_WIDTH - 1));
  end

endmodule

// File: rtl/log2_compress.sv
// ---------------------------------------------------------------------------
// log2_compress
// Four-stage log-compression pipeline for the ultrasound envelope path.
//   S1 leading-one detect, S2 LUT fraction correction, S3 per-channel gain,
//   S4 per-channel offset + clamp to the display code width.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input stream handshake
//   in_data/in_ch/in_last : sample, channel tag, end-of-line marker
//   cfg_we/cfg_ch         : config write strobe and target channel
//   cfg_gain/cfg_offset   : unsigned Q8.8 gain, signed offset in codes
//   clr_sat               : clears the sticky saturation flags
//   out_valid/out_ready   : output stream handshake
//   out_data/out_ch/out_last/out_sat : code, tags, per-sample clamp flag
//   sat_flags             : sticky per-channel saturation flags
// ---------------------------------------------------------------------------
module log2_compress
  import log_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int LUT_BITS   = 5,
  parameter int OUT_WIDTH  = 8,
  parameter int NUM_CH     = 4,
  parameter int GAIN_SHIFT = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [$clog2(NUM_CH)-1:0]   in_ch,
  input  logic                        in_last,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]   cfg_ch,
  input  logic [CFG_GAIN_WIDTH-1:0]   cfg_gain,
  input  logic signed [OUT_WIDTH:0]   cfg_offset,
  input  logic                        clr_sat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]   out_ch,
  output logic                        out_last,
  output logic                        out_sat,
  output logic [NUM_CH-1:0]           sat_flags
);

  localparam int CH_WIDTH     = $clog2(NUM_CH);
  localparam int SHIFT_WIDTH  = $clog2(DATA_WIDTH);
  localparam int LOG_WIDTH    = SHIFT_WIDTH + FRAC_WIDTH;
  localparam int PROD_WIDTH   = LOG_WIDTH + CFG_GAIN_WIDTH;
  localparam int SCALED_WIDTH = PROD_WIDTH - GAIN_SHIFT;
  localparam int OFF_WIDTH    = OUT_WIDTH + 1;
  localparam int RES_WIDTH    =
    ((SCALED_WIDTH > OFF_WIDTH) ? SCALED_WIDTH : OFF_WIDTH) + 2;
  localparam int LUT_DEPTH    = 1 << LUT_BITS;
  localparam logic signed [RES_WIDTH-1:0] CODE_MAX =
    RES_WIDTH'((1 << OUT_WIDTH) - 1);

  // Per-channel configuration
  logic [CFG_GAIN_WIDTH-1:0] gain_q   [NUM_CH];
  logic signed [OUT_WIDTH:0] offset_q [NUM_CH];

  // Stage registers
  logic                    s1Valid_q, s2Valid_q, s3Valid_q, s4Valid_q;
  logic [CH_WIDTH-1:0]     s1Ch_q, s2Ch_q, s3Ch_q, s4Ch_q;
  logic                    s1Last_q, s2Last_q, s3Last_q, s4Last_q;
  logic [SHIFT_WIDTH-1:0]  s1Exp_q;
  logic [FRAC_WIDTH-1:0]   s1Frac_q;
  logic [LOG_WIDTH-1:0]    s2Log_q;
  logic [PROD_WIDTH-1:0]   s3Prod_q;
  logic [OUT_WIDTH-1:0]    s4Data_q;
  logic                    s4Sat_q;
  logic [NUM_CH-1:0]       satFlags_q;

  // Next-state values
  logic [SHIFT_WIDTH-1:0]  s1Exp_d;
  logic [FRAC_WIDTH-1:0]   s1Frac_d;
  logic [LOG_WIDTH-1:0]    s2Log_d;
  logic [PROD_WIDTH-1:0]   s3Prod_d;
  logic [OUT_WIDTH-1:0]    s4Data_d;
  logic                    s4Sat_d;
  logic [NUM_CH-1:0]       satFlags_d;

  logic                    advance;
  logic [FRAC_WIDTH-1:0]   lutRom [LUT_DEPTH];
  logic [LUT_BITS-1:0]     lutIdx;
  logic [FRAC_WIDTH:0]     fracSum;
  logic [FRAC_WIDTH-1:0]   fracSat;
  logic [SCALED_WIDTH-1:0] scaled;
  logic [RES_WIDTH-1:0]    offExt;
  logic signed [RES_WIDTH-1:0] resSum;
  logic [NUM_CH-1:0]       satSet;

  // The whole pipe moves as one: it may advance whenever the output slot is
  // free or being drained this cycle. Bubbles are carried, not squeezed.
  assign advance  = out_ready || !s4Valid_q;
  assign in_ready = advance && !reset;

  assign out_valid = s4Valid_q;
  assign out_data  = s4Data_q;
  assign out_ch    = s4Ch_q;
  assign out_last  = s4Last_q;
  assign out_sat   = s4Sat_q;
  assign sat_flags = satFlags_q;

  // Correction table, folded to constants at elaboration
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
    assign lutRom[g] = FRAC_WIDTH'(lut_entry(g, LUT_BITS, FRAC_WIDTH));
  end

  log2_lod #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRAC_WIDTH  (FRAC_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_lod (
    .data_i (in_data),
    .exp_o  (s1Exp_d),
    .frac_o (s1Frac_d)
  );

  // S2: add the LUT correction indexed by the top mantissa bits; the sum can
  // exceed the fraction range near 2^(e+1), so it is pinned at all-ones.
  always_comb begin
    lutIdx  = s1Frac_q[FRAC_WIDTH-1 -: LUT_BITS];
    fracSum = {1'b0, s1Frac_q} + {1'b0, lutRom[lutIdx]};
    fracSat = fracSum[FRAC_WIDTH] ? {FRAC_WIDTH{1'b1}} : fracSum[FRAC_WIDTH-1:0];
    s2Log_d = {s1Exp_q, fracSat};
  end

  // S3: the gain register is read combinationally, so a write landing on the
  // same edge as the advance is seen only by later samples.
  always_comb begin
    s3Prod_d = PROD_WIDTH'(s2Log_q) * PROD_WIDTH'(gain_q[s2Ch_q]);
  end

  // S4: scale down, add the signed offset with headroom for both signs, then
  // clamp into the code range and flag any clamp.
  always_comb begin
    scaled = s3Prod_q[PROD_WIDTH-1:GAIN_SHIFT];
    offExt = {{(RES_WIDTH-OFF_WIDTH){offset_q[s3Ch_q][OUT_WIDTH]}}, offset_q[s3Ch_q]};
    resSum = $signed({{(RES_WIDTH-SCALED_WIDTH){1'b0}}, scaled}) + $signed(offExt);
    if (resSum < 0) begin
      s4Data_d = '0;
      s4Sat_d  = 1'b1;
    end else if (resSum > CODE_MAX) begin
      s4Data_d = '1;
      s4Sat_d  = 1'b1;
    end else begin
      s4Data_d = resSum[OUT_WIDTH-1:0];
      s4Sat_d  = 1'b0;
    end
  end

  // Sticky flags: a clear and a saturating load on the same edge leave the
  // saturating channel's bit set.
  always_comb begin
    satSet = '0;
    if (advance && s3Valid_q && s4Sat_d) satSet = NUM_CH'(1) << s3Ch_q;
    satFlags_d = (clr_sat ? '0 : satFlags_q) | satSet;
  end

  // Config, pipeline and flag registers. Reset drops anything in flight and
  // restores unity gain and zero offset on every channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        gain_q[c]   <= GAIN_ONE;
        offset_q[c] <= '0;
      end
      s1Valid_q  <= 1'b0;
      s2Valid_q  <= 1'b0;
      s3Valid_q  <= 1'b0;
      s4Valid_q  <= 1'b0;
      s1Ch_q     <= '0;
      s2Ch_q     <= '0;
      s3Ch_q     <= '0;
      s4Ch_q     <= '0;
      s1Last_q   <= 1'b0;
      s2Last_q   <= 1'b0;
      s3Last_q   <= 1'b0;
      s4Last_q   <= 1'b0;
      s1Exp_q    <= '0;
      s1Frac_q   <= '0;
      s2Log_q    <= '0;
      s3Prod_q   <= '0;
      s4Data_q   <= '0;
      s4Sat_q    <= 1'b0;
      satFlags_q <= '0;
    end else begin
      if (cfg_we) begin
        gain_q[cfg_ch]   <= cfg_gain;
        offset_q[cfg_ch] <= cfg_offset;
      end
      if (advance) begin
        s1Valid_q <= in_valid;
        s1Ch_q    <= in_ch;
        s1Last_q  <= in_last;
        s1Exp_q   <= s1Exp_d;
        s1Frac_q  <= s1Frac_d;
        s2Valid_q <= s1Valid_q;
        s2Ch_q    <= s1Ch_q;
        s2Last_q  <= s1Last_q;
        s2Log_q   <= s2Log_d;
        s3Valid_q <= s2Valid_q;
        s3Ch_q    <= s2Ch_q;
        s3Last_q  <= s2Last_q;
        s3Prod_q  <= s3Prod_d;
        s4Valid_q <= s3Valid_q;
        s4Ch_q    <= s3Ch_q;
        s4Last_q  <= s3Last_q;
        s4Data_q  <= s4Data_d;
        s4Sat_q   <= s4Sat_d;
      end
      satFlags_q <= satFlags_d;
    end
  end

endmodule

// File: tb/tb_log2_compress.sv
// ---------------------------------------------------------------------------
// tb_log2_compress
// Self-checking bench for log2_compress: directed table of single samples
// with hand-computed codes, saturation flag sequences, a full backpressure
// stall, a mid-stream reset and a randomized handshake run against a model.
// ---------------------------------------------------------------------------
module tb_log2_compress;

  localparam int DW  = 16;
  localparam int OW  = 8;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [CHW-1:0]  in_ch;
  logic            in_last;
  logic            cfg_we;
  logic [CHW-1:0]  cfg_ch;
  logic [15:0]     cfg_gain;
  logic [OW:0]     cfg_offset;
  logic            clr_sat;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic [CHW-1:0]  out_ch;
  logic            out_last;
  logic            out_sat;
  logic [NCH-1:0]  sat_flags;

  int tests = 0;
  int fails = 0;
  int lutRef [32];
  int gainM  [NCH];
  int offM   [NCH];

  typedef struct {
    bit doCfg; int cfgCh; int cfgGain; int cfgOff; bit clrBefore;
    int data; int ch; bit last; int expData; int expSat; int expFlags;
  } vec_t;

  typedef struct { int packedVal; } exp_t;

  exp_t expQ[$];

  log2_compress #(
    .DATA_WIDTH(16), .FRAC_WIDTH(8), .LUT_BITS(5),
    .OUT_WIDTH(8), .NUM_CH(4), .GAIN_SHIFT(12)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .in_last(in_last),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain),
    .cfg_offset(cfg_offset), .clr_sat(clr_sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .out_sat(out_sat),
    .sat_flags(sat_flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Floating-point reference for one sample
  function automatic void refModel(input int data, input int gain, input int off,
                                   output int code, output int sat);
    int e; int x; int frac; int logv; longint p; int r; longint m;
    e = 0;
    for (int b = 0; b < DW; b++) if (data[b]) e = b;
    m = longint'(data) << (8 + 15 - e);
    x = int'((m >> 15) & 255);
    frac = x + lutRef[x >> 3];
    if (frac > 255) frac = 255;
    logv = e * 256 + frac;
    p = longint'(logv) * longint'(gain);
    r = int'(p >> 12) + off;
    if (r < 0) begin code = 0; sat = 1; end
    else if (r > 255) begin code = 255; sat = 1; end
    else begin code = r; sat = 0; end
  endfunction

  function automatic int packOut(input int code, input int ch, input int last, input int sat);
    return (code << 4) | (ch << 2) | (last << 1) | sat;
  endfunction

  task automatic writeCfg(input int ch, input int gain, input int off);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_gain = 16'(gain); cfg_offset = (OW+1)'(off);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    gainM[ch] = gain; offM[ch] = off;
  endtask

  task automatic pulseClear();
    clr_sat = 1'b1;
    @(posedge clk); #1;
    clr_sat = 1'b0;
  endtask

  // One sample into an idle pipe; reports edges until out_valid (0 on timeout)
  task automatic applyStimulus(input int data, input int ch, input bit last,
                               output int lat, output int code, output int sat,
                               output int chOut, output int lastOut, output int flags);
    in_valid = 1'b1; in_data = DW'(data); in_ch = CHW'(ch); in_last = last;
    lat = 0; code = -1; sat = -1; chOut = -1; lastOut = -1; flags = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = i; code = int'(out_data); sat = int'(out_sat);
        chOut = int'(out_ch); lastOut = int'(out_last); flags = int'(sat_flags);
        break;
      end
    end
  endtask

  initial begin
    vec_t vecs [16];
    int lat, code, sat, chOut, lastOut, flags;
    int accepted, k, hold, got, sent, cycles, seen;
    int sd [6];
    int sc [6];
    int ecode, esat;
    exp_t ev;

    for (int i = 0; i < 32; i++)
      lutRef[i] = $rtoi((($ln(1.0 + i / 32.0) / $ln(2.0)) - i / 32.0) * 256.0 + 0.5);
    for (int c = 0; c < NCH; c++) begin gainM[c] = 256; offM[c] = 0; end

    //          cfg ch  gain    off  clr data     ch last exp  sat flags
    vecs[0]  = '{0, 0, 'h100,    0, 0, 'h0100, 0, 0, 128, 0, 'b0000};
    vecs[1]  = '{0, 0, 'h100,    0, 0, 'hFFFF, 0, 1, 255, 0, 'b0000};
    vecs[2]  = '{0, 0, 'h100,    0, 0, 'h0003, 0, 0,  25, 0, 'b0000};
    vecs[3]  = '{0, 0, 'h100,    0, 0, 'h0000, 0, 0,   0, 0, 'b0000};
    vecs[4]  = '{0, 0, 'h100,    0, 0, 'h0001, 0, 0,   0, 0, 'b0000};
    vecs[5]  = '{0, 0, 'h100,    0, 0, 'h8000, 0, 0, 240, 0, 'b0000};
    vecs[6]  = '{0, 0, 'h100,    0, 0, 'h00FF, 3, 1, 127, 0, 'b0000};
    vecs[7]  = '{0, 0, 'h100,    0, 0, 'h0002, 3, 0,  16, 0, 'b0000};
    vecs[8]  = '{1, 2, 'h100,  -10, 0, 'h0100, 2, 0, 118, 0, 'b0000};
    vecs[9]  = '{0, 0, 'h100,    0, 0, 'h0100, 1, 0, 128, 0, 'b0000};
    vecs[10] = '{1, 2, 'h100, -200, 0, 'h0100, 2, 1,   0, 1, 'b0100};
    vecs[11] = '{1, 1, 'h200,    0, 1, 'h0100, 1, 0, 255, 1, 'b0010};
    vecs[12] = '{1, 3, 'h100,  255, 0, 'hFFFF, 3, 0, 255, 1, 'b1010};
    vecs[13] = '{0, 0, 'h100,    0, 0, 'h0000, 3, 1, 255, 0, 'b1010};
    vecs[14] = '{1, 0, 'h000,    0, 0, 'hFFFF, 0, 0,   0, 0, 'b1010};
    vecs[15] = '{1, 0, 'h100,   -1, 0, 'h0000, 0, 0,   0, 1, 'b1011};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; in_last = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_gain = '0; cfg_offset = '0;
    clr_sat = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_tags", int'({out_ch, out_last, out_sat}), 0);
    checkOutput("rst_sat_flags", int'(sat_flags), 0);
    reset = 1'b0;
    #1;
    checkOutput("rst_release_in_ready", int'(in_ready), 1);

    // Directed table
    for (int v = 0; v < 16; v++) begin
      if (vecs[v].clrBefore) pulseClear();
      if (vecs[v].doCfg) writeCfg(vecs[v].cfgCh, vecs[v].cfgGain, vecs[v].cfgOff);
      applyStimulus(vecs[v].data, vecs[v].ch, vecs[v].last, lat, code, sat, chOut, lastOut, flags);
      checkOutput($sformatf("vec%0d_latency", v), lat, 4);
      checkOutput($sformatf("vec%0d_data", v), code, vecs[v].expData);
      checkOutput($sformatf("vec%0d_sat", v), sat, vecs[v].expSat);
      checkOutput($sformatf("vec%0d_tags", v), chOut * 2 + lastOut, vecs[v].ch * 2 + int'(vecs[v].last));
      checkOutput($sformatf("vec%0d_flags", v), flags, vecs[v].expFlags);
    end

    // Clear pulse empties the sticky flags
    @(posedge clk); #1;
    pulseClear();
    checkOutput("clr_sat_pulse", int'(sat_flags), 0);

    // Clear coinciding with a saturating load into S4: the set wins
    in_valid = 1'b1; in_data = 16'h0100; in_ch = 2'd2; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr_sat = 1'b1;
    @(posedge clk); #1;
    clr_sat = 1'b0;
    checkOutput("clr_vs_set_flags", int'(sat_flags), 'b0100);
    checkOutput("clr_vs_set_out", int'({out_valid, out_sat}), 3);
    @(posedge clk); #1;

    // Backpressure: fill the pipe with out_ready low, then drain
    sd = '{'h0100, 'h0003, 'hFFFF, 'h0040, 'h1234, 'h0007};
    sc = '{0, 1, 2, 3, 1, 0};
    out_ready = 1'b0; accepted = 0; k = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = DW'(sd[k]); in_ch = CHW'(sc[k]); in_last = (k == 3);
      #1;
      if (in_valid && in_ready) begin
        refModel(sd[k], gainM[sc[k]], offM[sc[k]], ecode, esat);
        ev.packedVal = packOut(ecode, sc[k], int'(k == 3), esat);
        expQ.push_back(ev);
        accepted++; k++;
      end
    end
    in_valid = 1'b0;
    checkOutput("stall_accepted", accepted, 4);
    checkOutput("stall_in_ready", int'(in_ready), 0);
    checkOutput("stall_out_valid", int'(out_valid), 1);
    hold = packOut(int'(out_data), int'(out_ch), int'(out_last), int'(out_sat));
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("stall_hold_stable", packOut(int'(out_data), int'(out_ch), int'(out_last), int'(out_sat)), hold);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) checkOutput("stall_extra_output", 1, 0);
        else begin
          ev = expQ.pop_front();
          checkOutput("stall_drain", packOut(int'(out_data), int'(out_ch), int'(out_last), int'(out_sat)), ev.packedVal);
        end
      end
      @(posedge clk); #1;
    end
    checkOutput("stall_queue_empty", expQ.size(), 0);
    expQ.delete();

    // Reset with three samples in flight (config is non-default beforehand)
    in_valid = 1'b1; in_data = 16'h0100; in_ch = 2'd1; in_last = 1'b0;
    @(posedge clk); #1;
    in_ch = 2'd2;
    @(posedge clk); #1;
    in_ch = 2'd3; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready_low", int'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_in_ready_back", int'(in_ready), 1);
    for (int c = 0; c < NCH; c++) begin gainM[c] = 256; offM[c] = 0; end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("midrst_no_output", seen, 0);
    checkOutput("midrst_sat_flags", int'(sat_flags), 0);
    applyStimulus('h0100, 1, 0, lat, code, sat, chOut, lastOut, flags);
    checkOutput("midrst_gain_default", code, 128);
    applyStimulus('h0100, 2, 0, lat, code, sat, chOut, lastOut, flags);
    checkOutput("midrst_offset_default", code, 128);
    checkOutput("midrst_latency", lat, 4);

    // Random valid/ready against the model
    writeCfg(1, 'h0180, -20);
    writeCfg(2, 'h00C0, 30);
    writeCfg(3, 'h0300, -100);
    sent = 0; got = 0; cycles = 0;
    while (got < 1000 && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
      if (sent < 1000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = DW'($urandom_range(0, 65535) >> $urandom_range(0, 15));
        in_ch    = CHW'($urandom_range(0, 3));
        in_last  = ($urandom_range(0, 7) == 0);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) checkOutput("rand_extra_output", 1, 0);
        else begin
          ev = expQ.pop_front();
          checkOutput("rand_out", packOut(int'(out_data), int'(out_ch), int'(out_last), int'(out_sat)), ev.packedVal);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        refModel(int'(in_data), gainM[in_ch], offM[in_ch], ecode, esat);
        ev.packedVal = packOut(ecode, int'(in_ch), int'(in_last), esat);
        expQ.push_back(ev);
        sent++;
      end
    end
    in_valid = 1'b0;
    checkOutput("rand_outputs_seen", got, 1000);
    checkOutput("rand_queue_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
